bar_level_gen: RTL and testbench
================================

# bar_level_gen

Per-frame producer of the bar length (`value`) and bar top row (`y1`) consumed by the HDMI bar-draw logic. It sits between a sample source (or its own built-in bounce animator) and the draw stage. It updates its outputs only at frame boundaries (rising `vsync`), so a bar never tears mid-frame. It provides two modes:
- **LEVEL:** peak-hold meter with linear decay, fed by a valid/ready sample stream.
- **BOUNCE:** test pattern sweeping the bar across the active width.

## Interface
- `X_BITS`, 13, width of `value`, `total_active_pix`, `sample_data`
- `Y_BITS`, 13, width of `y1`
- `Y_POS`, 100, constant top row driven on `y1`
- `STEP`, 4, BOUNCE increment per frame (≥1)
- `DECAY`, 2, LEVEL fall per frame (≥0)

Ports:
- `clk` in 1: pixel clock; the only clock.
- `rst_n` in 1: reset, synchronous, active-low.
- `vsync` in 1: frame sync, synchronous to `clk`, active-high.
- `total_active_pix` in X_BITS: active width; MAX = `total_active_pix`−1.
- `mode` in 1: 0 = BOUNCE, 1 = LEVEL. Sampled only at a frame tick.
- `sample_data` in X_BITS: level sample.
- `sample_valid` in 1: sample handshake valid.
- `sample_ready` out 1: sample handshake ready.
- `value` out X_BITS: registered bar length.
- `y1` out Y_BITS: always `Y_POS`.
- `frame_tick` out 1: one-cycle pulse coincident with each new `value`.

## Operation
- **Reset** (`rst_n`=0 at a clk edge) forces:
  - `value`=0, `frame_tick`=0, `sample_ready`=0.
  - State IDLE, internal `peak`=0, `vsync_q`=0.
  - `y1`=`Y_POS` at all times.
- **Tick.** Tick edge = clk edge where `vsync`=1 and `vsync_q`=0. `vsync_q` registers `vsync` every cycle.
- **States:** IDLE, BOUNCE_UP, BOUNCE_DOWN, LEVEL.
- **Effect of a tick edge:**
  - Target state from `mode`:
    - `mode`=1 → LEVEL.
    - `mode`=0 from BOUNCE_UP/BOUNCE_DOWN → unchanged.
    - `mode`=0 from IDLE/LEVEL → BOUNCE_UP.
  - The target state's rule is then applied in the same edge.
  - Outside tick edges, state and `value` hold.
- **BOUNCE_UP:**
  - If `value`+STEP ≥ MAX: `value`=MAX, go to BOUNCE_DOWN.
  - Else `value`+=STEP.
- **BOUNCE_DOWN:**
  - If `value` ≤ STEP: `value`=0, go to BOUNCE_UP.
  - Else `value`−=STEP.
- **LEVEL:**
  - `value` = min(MAX, max(`peak`, sat0(`value`−DECAY))).
  - `peak` resets to 0, or to `sample_data` if a sample is accepted on the same edge.
- **Samples:**
  - `sample_ready` = (state==LEVEL), registered.
  - A sample is accepted on an edge with `sample_valid`&&`sample_ready`.
  - On a non-tick edge, `peak`=max(`peak`,`sample_data`).
  - A sample accepted on a tick edge belongs to the new frame: it is not used in that edge's `value` calc.
  - No backpressure inside LEVEL; in other states samples are not accepted.
- **Arithmetic:**
  - Sums and differences use X_BITS+1 bits, so there is no wrap.
  - `sample_data` > MAX clamps to MAX.
  - `total_active_pix`=0 is treated as MAX=0.
- **Resolution shrink:** if `value` > MAX at a tick, it is clamped to MAX in any state. BOUNCE_UP then goes to BOUNCE_DOWN.

## Timing
- `value`, state and `frame_tick` all change on the tick edge.
- `frame_tick` is high for exactly the one cycle following the tick edge.
- A `vsync` held high for many cycles produces one tick. The next tick requires `vsync` to be sampled low at least once.
- Latency: a `vsync` rise sampled at edge N gives the new `value` visible after edge N. Draw logic sees it for the whole next frame.
- `sample_ready` changes only one cycle after a tick edge, and stays 0 until the first tick after reset.
- Reset mid-frame discards the accumulated `peak`. The first tick after reset leaves IDLE, with `value` computed from 0.
- Reset asserted on a tick edge wins: that tick is lost.

## Test plan
- **Reset:** `rst_n`=0 for 4 clocks with `vsync` toggling → `value`=0, `y1`=100, `sample_ready`=0, `frame_tick`=0 throughout.
- **Bounce:** `mode`=0, `total_active_pix`=11, 7 ticks → `value` sequence 4,8,10,6,2,0,4. `frame_tick` pulses once per tick; `vsync` held high 50 clocks gives a single tick.
- **Level peak/decay:**
  - `mode`=1; one tick to enter LEVEL (`value` 0).
  - Samples 3,9,5 then tick → 9.
  - No samples, tick → 7.
  - Sample 6, tick → 6.
  - Ticks with no samples → 4,2,0,0.
- **Simultaneous:** in LEVEL with `value`=0, sample 8 on the tick edge → `value` stays 0. Next tick → 8.
- **Clamp:** LEVEL, `total_active_pix`=1920, sample 5000 → `value`=1919. Then `total_active_pix`=100, tick → `value`=99.
- **Mode/reset mid-operation:**
  - LEVEL at `value`=10, `mode`→0, tick → 14 (BOUNCE_UP); `sample_ready` falls one cycle after the tick.
  - Reset mid-frame after sample 50 → next tick gives `value` 0 and `sample_ready` rising one cycle after the tick.

Source files
------------

// File: rtl/bar_level_gen.sv
// Per-frame bar length generator: peak-hold level meter or bounce test pattern.
// Outputs update only on the rising edge of vsync so a bar never tears mid-frame.
module bar_level_gen #(
   parameter int X_BITS = 13,
   parameter int Y_BITS = 13,
   parameter int Y_POS  = 100,
   parameter int STEP   = 4,
   parameter int DECAY  = 2
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              vsync,
   input  logic [X_BITS-1:0] total_active_pix,
   input  logic              mode,
   input  logic [X_BITS-1:0] sample_data,
   input  logic              sample_valid,
   output logic              sample_ready,
   output logic [X_BITS-1:0] value,
   output logic [Y_BITS-1:0] y1,
   output logic              frame_tick
);

   localparam int W = X_BITS + 1;

   typedef enum logic [1:0] {
      S_IDLE,
      S_BOUNCE_UP,
      S_BOUNCE_DOWN,
      S_LEVEL
   } state_t;

   state_t            state_q, state_d, target_state;
   logic [X_BITS-1:0] value_q, value_d;
   logic [X_BITS-1:0] peak_q, peak_d;
   logic              vsync_q;
   logic              ready_q;
   logic              frame_tick_q;
   logic              tick;
   logic              accept;

   logic [W-1:0]      max_w;
   logic [W-1:0]      value_w;
   logic [W-1:0]      value_clamped_w;
   logic [W-1:0]      step_w;
   logic [W-1:0]      decay_w;
   logic [W-1:0]      peak_w;
   logic [W-1:0]      up_sum_w;
   logic [W-1:0]      decayed_w;
   logic [W-1:0]      level_w;
   logic [W-1:0]      level_clamped_w;
   logic [X_BITS-1:0] step_x;

   assign tick   = vsync && !vsync_q;
   assign accept = sample_valid && ready_q;

   // A zero width is treated as MAX = 0 rather than wrapping to all-ones.
   assign max_w = (total_active_pix == '0) ? '0 : ({1'b0, total_active_pix} - W'(1));

   assign value_w         = {1'b0, value_q};
   assign peak_w          = {1'b0, peak_q};
   assign step_w          = W'(STEP);
   assign decay_w         = W'(DECAY);
   assign step_x          = X_BITS'(STEP);
   assign value_clamped_w = (value_w > max_w) ? max_w : value_w;
   assign up_sum_w        = value_clamped_w + step_w;
   assign decayed_w       = (value_w >= decay_w) ? (value_w - decay_w) : '0;
   assign level_w         = (peak_w > decayed_w) ? peak_w : decayed_w;
   assign level_clamped_w = (level_w > max_w) ? max_w : level_w;

   always_comb begin
      target_state = state_q;
      if (mode) begin
         target_state = S_LEVEL;
      end else if (state_q == S_IDLE || state_q == S_LEVEL) begin
         target_state = S_BOUNCE_UP;
      end
   end

   always_comb begin
      state_d = state_q;
      value_d = value_q;
      peak_d  = peak_q;
      if (tick) begin
         // A sample taken on the tick edge seeds the next frame's peak only.
         peak_d  = accept ? sample_data : '0;
         state_d = target_state;
         case (target_state)
            S_BOUNCE_UP: begin
               if (up_sum_w >= max_w) begin
                  value_d = max_w[X_BITS-1:0];
                  state_d = S_BOUNCE_DOWN;
               end else begin
                  value_d = up_sum_w[X_BITS-1:0];
               end
            end
            S_BOUNCE_DOWN: begin
               if (value_clamped_w <= step_w) begin
                  value_d = '0;
                  state_d = S_BOUNCE_UP;
               end else begin
                  value_d = value_clamped_w[X_BITS-1:0] - step_x;
               end
            end
            S_LEVEL: begin
               value_d = level_clamped_w[X_BITS-1:0];
            end
            default: begin
               value_d = value_q;
            end
         endcase
      end else if (accept && (sample_data > peak_q)) begin
         peak_d = sample_data;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q      <= S_IDLE;
         value_q      <= '0;
         peak_q       <= '0;
         vsync_q      <= 1'b0;
         ready_q      <= 1'b0;
         frame_tick_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         value_q      <= value_d;
         peak_q       <= peak_d;
         vsync_q      <= vsync;
         // Ready follows the registered state, so it moves one cycle after a tick.
         ready_q      <= (state_q == S_LEVEL);
         frame_tick_q <= tick;
      end
   end

   assign sample_ready = ready_q;
   assign value        = value_q;
   assign frame_tick   = frame_tick_q;
   assign y1           = Y_BITS'(Y_POS);

endmodule

// File: tb/tb_bar_level_gen.sv
// Scoreboard bench for bar_level_gen: expected bar lengths are queued per driven
// frame and compared whenever the DUT pulses frame_tick.
module tb_bar_level_gen;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        vsync;
   logic [12:0] total_active_pix;
   logic        mode;
   logic [12:0] sample_data;
   logic        sample_valid;
   logic        sample_ready;
   logic [12:0] value;
   logic [12:0] y1;
   logic        frame_tick;

   int    n_checks = 0;
   int    n_pass   = 0;
   int    ft_count = 0;
   int    exp_q[$];
   string cur_tag  = "none";

   always #5 clk = ~clk;

   bar_level_gen dut (
      .clk              (clk),
      .rst_n            (rst_n),
      .vsync            (vsync),
      .total_active_pix (total_active_pix),
      .mode             (mode),
      .sample_data      (sample_data),
      .sample_valid     (sample_valid),
      .sample_ready     (sample_ready),
      .value            (value),
      .y1               (y1),
      .frame_tick       (frame_tick)
   );

   task automatic check_val(input string tag, input int got, input int exp);
      n_checks++;
      if (got == exp) begin
         n_pass++;
         $display("check %-16s got %0d expected %0d", tag, got, exp);
      end else begin
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   // Scoreboard pop: every frame_tick pulse must match one queued frame.
   always @(negedge clk) begin
      if (frame_tick === 1'b1) begin
         ft_count++;
         if (exp_q.size() == 0) begin
            check_val("unexpected_tick", 1, 0);
         end else begin
            check_val(cur_tag, int'(value), exp_q.pop_front());
         end
      end
   end

   // Drive one vsync rise held for 'hold' extra cycles; optionally present a
   // sample on the tick edge itself. Ready is checked before/after its delayed update.
   task automatic frame(input string tag, input int exp, input int hold,
                        input bit rdy_old, input bit rdy_new,
                        input bit with_sample = 1'b0, input int sdata = 0);
      int ft_before;
      ft_before = ft_count;
      cur_tag   = tag;
      exp_q.push_back(exp);
      vsync = 1'b1;
      if (with_sample) begin
         sample_valid = 1'b1;
         sample_data  = 13'(sdata);
      end
      @(negedge clk);
      sample_valid = 1'b0;
      check_val({tag, "_rdy_old"}, int'(sample_ready), int'(rdy_old));
      @(negedge clk);
      check_val({tag, "_rdy_new"}, int'(sample_ready), int'(rdy_new));
      repeat (hold) @(negedge clk);
      vsync = 1'b0;
      repeat (2) @(negedge clk);
      check_val({tag, "_ticks"}, ft_count - ft_before, 1);
      check_val({tag, "_pending"}, exp_q.size(), 0);
      exp_q.delete();
   endtask

   task automatic send_sample(input int d);
      sample_valid = 1'b1;
      sample_data  = 13'(d);
      @(negedge clk);
      sample_valid = 1'b0;
   endtask

   task automatic do_reset(input int n);
      rst_n = 1'b0;
      repeat (n) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      rst_n            = 1'b0;
      vsync            = 1'b0;
      total_active_pix = 13'd11;
      mode             = 1'b0;
      sample_data      = '0;
      sample_valid     = 1'b0;

      // Reset held with vsync toggling: outputs stay idle every cycle.
      for (int i = 0; i < 4; i++) begin
         vsync = (i % 2 == 0);
         @(negedge clk);
         check_val("rst_value", int'(value), 0);
         check_val("rst_y1", int'(y1), 100);
         check_val("rst_ready", int'(sample_ready), 0);
         check_val("rst_tick", int'(frame_tick), 0);
      end
      vsync = 1'b0;
      rst_n = 1'b1;
      repeat (2) @(negedge clk);

      // Bounce across MAX = 10; the first frame holds vsync high for 50 clocks.
      frame("b1", 4, 50, 1'b0, 1'b0);
      frame("b2", 8, 1, 1'b0, 1'b0);
      frame("b3", 10, 1, 1'b0, 1'b0);
      frame("b4", 6, 1, 1'b0, 1'b0);
      frame("b5", 2, 1, 1'b0, 1'b0);
      frame("b6", 0, 1, 1'b0, 1'b0);
      frame("b7", 4, 1, 1'b0, 1'b0);

      // Level meter peak hold and decay.
      do_reset(2);
      mode             = 1'b1;
      total_active_pix = 13'd1920;
      frame("l0", 0, 1, 1'b0, 1'b1);
      send_sample(3);
      send_sample(9);
      send_sample(5);
      frame("l1", 9, 1, 1'b1, 1'b1);
      frame("l2", 7, 1, 1'b1, 1'b1);
      send_sample(6);
      frame("l3", 6, 1, 1'b1, 1'b1);
      frame("l4", 4, 1, 1'b1, 1'b1);
      frame("l5", 2, 1, 1'b1, 1'b1);
      frame("l6", 0, 1, 1'b1, 1'b1);
      frame("l7", 0, 1, 1'b1, 1'b1);

      // Sample on the tick edge belongs to the next frame.
      frame("s1", 0, 1, 1'b1, 1'b1, 1'b1, 8);
      frame("s2", 8, 1, 1'b1, 1'b1);

      // Over-range sample and resolution shrink.
      send_sample(5000);
      frame("c1", 1919, 1, 1'b1, 1'b1);
      total_active_pix = 13'd100;
      frame("c2", 99, 1, 1'b1, 1'b1);

      // Mode change to bounce, then reset mid-frame discarding the peak.
      do_reset(2);
      total_active_pix = 13'd1920;
      frame("m0", 0, 1, 1'b0, 1'b1);
      send_sample(10);
      frame("m1", 10, 1, 1'b1, 1'b1);
      mode = 1'b0;
      frame("m2", 14, 1, 1'b1, 1'b0);
      mode = 1'b1;
      frame("m3", 12, 1, 1'b0, 1'b1);
      send_sample(50);
      do_reset(2);
      check_val("mrst_ready", int'(sample_ready), 0);
      check_val("mrst_value", int'(value), 0);
      frame("m4", 0, 1, 1'b0, 1'b1);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
